// File: rtl/coverfloat_vector_fifo.sv
// First-word-fall-through FIFO for coverfloat covervectors with sequence tagging.
// Supports stall-on-full or drop-on-full with a saturating drop counter.
module coverfloat_vector_fifo #(
    parameter int DEPTH        = 8,
    parameter int OPW          = 128,
    parameter int MW           = 192,
    parameter int SEQ_W        = 16,
    parameter int DROP_ON_FULL = 0,
    localparam int VEC_W       = 4*OPW + MW + 97,
    localparam int CW          = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [VEC_W-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [VEC_W-1:0] out_vec,
    output logic [SEQ_W-1:0] out_seq,
    output logic [CW-1:0]    count,
    output logic [SEQ_W-1:0] dropped
);
    localparam int PW = $clog2(DEPTH);

    logic [VEC_W-1:0] mem_r     [DEPTH];
    logic [SEQ_W-1:0] seq_mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [SEQ_W-1:0] seq_r;
    logic [SEQ_W-1:0] dropped_r;

    logic full_s;
    logic empty_s;
    logic in_ready_s;
    logic pop_s;
    logic push_s;
    logic drop_s;

    // Handshake decode; flush suppresses every transfer in its cycle.
    always_comb begin
        full_s     = (count_r == CW'(DEPTH));
        empty_s    = (count_r == {CW{1'b0}});
        in_ready_s = (DROP_ON_FULL != 0) ? 1'b1 : !full_s;
        pop_s      = 1'b0;
        push_s     = 1'b0;
        drop_s     = 1'b0;
        if (!flush) begin
            pop_s = !empty_s && out_ready;
            if (in_valid && in_ready_s) begin
                if (!full_s || pop_s) begin
                    push_s = 1'b1;
                end else begin
                    drop_s = 1'b1;
                end
            end else begin
                push_s = 1'b0;
            end
        end else begin
            pop_s = 1'b0;
        end
    end

    // Storage is left unreset; it is only observed while out_valid is high.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r]     <= in_vec;
            seq_mem_r[wr_ptr_r] <= seq_r;
        end
    end

    // Pointers, occupancy, sequence tag and drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r  <= {PW{1'b0}};
            rd_ptr_r  <= {PW{1'b0}};
            count_r   <= {CW{1'b0}};
            seq_r     <= {SEQ_W{1'b0}};
            dropped_r <= {SEQ_W{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            if (push_s || drop_s) begin
                seq_r <= seq_r + SEQ_W'(1);
            end
            if (drop_s && (dropped_r != {SEQ_W{1'b1}})) begin
                dropped_r <= dropped_r + SEQ_W'(1);
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = !empty_s;
    assign out_vec   = mem_r[rd_ptr_r];
    assign out_seq   = seq_mem_r[rd_ptr_r];
    assign count     = count_r;
    assign dropped   = dropped_r;

endmodule

// File: tb/tb_coverfloat_vector_fifo.sv
// Bench for coverfloat_vector_fifo: one stall-mode and one drop-mode instance,
// each compared every cycle against a queue-based reference model.
module tb_coverfloat_vector_fifo;
    localparam int VW = 801;
    localparam int SW = 16;
    localparam int CW = 4;
    localparam int D  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          s_flush, s_iv, s_or, s_ir, s_ov;
    logic          d_flush, d_iv, d_or, d_ir, d_ov;
    logic [VW-1:0] s_vec, s_ovec, d_vec, d_ovec;
    logic [SW-1:0] s_oseq, s_drp, d_oseq, d_drp;
    logic [CW-1:0] s_cnt, d_cnt;

    coverfloat_vector_fifo #(.DROP_ON_FULL(0)) u_stall (
        .clk(clk), .rst(rst), .flush(s_flush), .in_valid(s_iv), .in_ready(s_ir),
        .in_vec(s_vec), .out_valid(s_ov), .out_ready(s_or), .out_vec(s_ovec),
        .out_seq(s_oseq), .count(s_cnt), .dropped(s_drp));

    coverfloat_vector_fifo #(.DROP_ON_FULL(1)) u_drop (
        .clk(clk), .rst(rst), .flush(d_flush), .in_valid(d_iv), .in_ready(d_ir),
        .in_vec(d_vec), .out_valid(d_ov), .out_ready(d_or), .out_vec(d_ovec),
        .out_seq(d_oseq), .count(d_cnt), .dropped(d_drp));

    typedef struct packed {
        logic [VW-1:0] vec;
        logic [SW-1:0] seq;
    } ent_t;

    ent_t sq[$];
    ent_t dq[$];
    int   s_seq = 0, d_seq = 0, s_dr = 0, d_dr = 0;
    int   tests = 0, fails = 0;

    task automatic check_val(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] rand_vec();
        logic [831:0] t;
        for (int i = 0; i < 26; i++) t[i*32 +: 32] = $urandom;
        return t[VW-1:0];
    endfunction

    // Reference behaviour: queue of {vector, tag}; pop first, then accept or drop.
    task automatic model_edge(ref ent_t q[$], ref int seqc, ref int drp, input bit dm,
                              input bit iv, input bit ordy, input bit fl, input logic [VW-1:0] vec);
        bit   full, pop;
        ent_t e;
        if (rst) begin
            q.delete(); seqc = 0; drp = 0;
        end else if (fl) begin
            q.delete();
        end else begin
            full = (q.size() == D);
            pop  = ordy && (q.size() > 0);
            if (pop) void'(q.pop_front());
            if (iv) begin
                if (!full || (dm && pop)) begin
                    e.vec = vec; e.seq = seqc[SW-1:0];
                    q.push_back(e);
                    seqc = (seqc + 1) % 65536;
                end else if (dm) begin
                    if (drp < 65535) drp++;
                    seqc = (seqc + 1) % 65536;
                end
            end
        end
    endtask

    task automatic check_outs();
        check_val("s_count", s_cnt, sq.size());
        check_val("s_out_valid", s_ov, sq.size() != 0);
        check_val("s_in_ready", s_ir, sq.size() != D);
        check_val("s_dropped", s_drp, s_dr);
        if (sq.size() != 0) begin
            check_val("s_out_vec", s_ovec, sq[0].vec);
            check_val("s_out_seq", s_oseq, sq[0].seq);
        end
        check_val("d_count", d_cnt, dq.size());
        check_val("d_out_valid", d_ov, dq.size() != 0);
        check_val("d_in_ready", d_ir, 1'b1);
        check_val("d_dropped", d_drp, d_dr);
        if (dq.size() != 0) begin
            check_val("d_out_vec", d_ovec, dq[0].vec);
            check_val("d_out_seq", d_oseq, dq[0].seq);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(sq, s_seq, s_dr, 1'b0, s_iv, s_or, s_flush, s_vec);
        model_edge(dq, d_seq, d_dr, 1'b1, d_iv, d_or, d_flush, d_vec);
        @(negedge clk);
        check_outs();
    endtask

    task automatic idle_all();
        rst = 1'b0; s_flush = 1'b0; d_flush = 1'b0;
        s_iv = 1'b0; d_iv = 1'b0; s_or = 1'b0; d_or = 1'b0;
    endtask

    logic [VW-1:0] special;
    int            seq_before;

    initial begin
        idle_all();
        s_vec = '0; d_vec = '0;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        check_val("rst_s_in_ready", s_ir, 1'b1);
        check_val("rst_d_in_ready", d_ir, 1'b1);
        check_val("rst_s_out_valid", s_ov, 1'b0);
        check_val("rst_d_count", d_cnt, 4'd0);

        // Fill both, then 3 extra offers: stall holds, drop discards.
        for (int i = 0; i < 11; i++) begin
            s_iv = 1'b1; d_iv = 1'b1; s_vec = rand_vec(); d_vec = rand_vec();
            step();
        end
        check_val("stall_full_count", s_cnt, 4'd8);
        check_val("stall_full_in_ready", s_ir, 1'b0);
        check_val("drop_full_count", d_cnt, 4'd8);
        check_val("drop_dropped3", d_drp, 16'd3);
        s_or = 1'b1; d_iv = 1'b0;
        step();
        s_or = 1'b0;
        check_val("stall_pop_count", s_cnt, 4'd7);
        check_val("stall_pop_in_ready", s_ir, 1'b1);
        s_iv = 1'b0;
        d_or = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_val("drop_drain_seq", d_oseq, SW'(i));
            step();
        end
        d_or = 1'b0; d_iv = 1'b1; d_vec = rand_vec();
        step();
        d_iv = 1'b0;
        check_val("drop_after_gap_seq", d_oseq, 16'd11);

        // Sustained push+pop on a full drop-mode FIFO wraps the pointers.
        rst = 1'b1; step(); rst = 1'b0;
        d_iv = 1'b1;
        for (int i = 0; i < 8; i++) begin d_vec = rand_vec(); step(); end
        d_or = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check_val("drop_stream_seq", d_oseq, SW'(i));
            d_vec = rand_vec();
            step();
            check_val("drop_stream_count", d_cnt, 4'd8);
            check_val("drop_stream_dropped", d_drp, 16'd0);
        end
        idle_all();

        // Bit-exact FWFT latency and hold under backpressure.
        s_flush = 1'b1; d_flush = 1'b1; step(); s_flush = 1'b0; d_flush = 1'b0;
        special = '0;
        special[VW-1 -: 32]  = 32'h1;
        special[VW-41 -: 128] = {128{1'b1}};
        special[7:0]         = 8'h1F;
        s_iv = 1'b1; s_vec = special;
        step();
        s_iv = 1'b0;
        check_val("special_valid", s_ov, 1'b1);
        check_val("special_vec", s_ovec, special);
        for (int i = 0; i < 5; i++) begin
            step();
            check_val("special_hold", s_ovec, special);
        end

        // Flush with a concurrent push, then reset at count 3.
        s_flush = 1'b1; step(); s_flush = 1'b0;
        s_iv = 1'b1;
        for (int i = 0; i < 5; i++) begin s_vec = rand_vec(); step(); end
        check_val("pre_flush_count", s_cnt, 4'd5);
        seq_before = s_seq;
        s_flush = 1'b1; s_vec = rand_vec();
        step();
        s_flush = 1'b0;
        check_val("flush_count", s_cnt, 4'd0);
        check_val("flush_out_valid", s_ov, 1'b0);
        for (int i = 0; i < 3; i++) begin s_vec = rand_vec(); step(); end
        s_iv = 1'b0;
        check_val("flush_keeps_seq", s_oseq, seq_before[SW-1:0]);
        rst = 1'b1; step(); rst = 1'b0;
        check_val("rst3_count", s_cnt, 4'd0);
        check_val("rst3_out_valid", s_ov, 1'b0);
        check_val("rst3_in_ready", s_ir, 1'b1);

        // Randomised traffic on both instances.
        for (int c = 0; c < 3000; c++) begin
            rst     = ($urandom_range(0, 399) == 0);
            s_flush = ($urandom_range(0, 59) == 0);
            d_flush = ($urandom_range(0, 59) == 0);
            s_iv    = ($urandom_range(0, 3) != 0);
            d_iv    = ($urandom_range(0, 3) != 0);
            s_or    = ($urandom_range(0, 2) == 0);
            d_or    = ($urandom_range(0, 2) == 0);
            s_vec   = rand_vec();
            d_vec   = rand_vec();
            step();
        end
        idle_all();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
